// File: rtl/cpi_calculator_if.sv
// cpi_calculator_if: retire/halt inputs and CPI result outputs of the CPI calculator
interface cpi_calculator_if #(
  parameter int CNT_W = 16
);
  logic             i_clear;
  logic             i_instr_retired;
  logic             i_processor_hlt;
  logic [CNT_W-1:0] i_cycle_count;
  logic [CNT_W-1:0] o_instr_count;
  logic [CNT_W-1:0] o_cpi;
  logic             o_valid;
  logic             o_busy;
  logic             o_div_by_zero;
  logic             o_saturated;
  modport slave (
    input  i_clear, i_instr_retired, i_processor_hlt, i_cycle_count,
    output o_instr_count, o_cpi, o_valid, o_busy, o_div_by_zero, o_saturated
  );
  modport master (
    output i_clear, i_instr_retired, i_processor_hlt, i_cycle_count,
    input  o_instr_count, o_cpi, o_valid, o_busy, o_div_by_zero, o_saturated
  );
endinterface

// File: rtl/cpi_calculator.sv
// cpi_calculator: counts retired instructions until halt, then divides the frozen cycle count by them into fixed-point CPI
module cpi_calculator #(
  parameter int CNT_W     = 16,
  parameter int FRAC_BITS = 8
) (
  input logic             clk,
  input logic             reset,
  cpi_calculator_if.slave bus
);
  localparam int DW = CNT_W + FRAC_BITS;
  localparam int IW = $clog2(DW + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, DIV, FINISH, DONE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, r_n, r_cpi;
  logic [DW-1:0]    r_dvd, r_quo;
  logic [CNT_W:0]   r_rem, w_rem_sh, w_rem_nx;
  logic [IW-1:0]    r_iter;
  logic             r_valid, r_busy, r_dbz, r_sat, w_ge, w_last, w_hi;
  assign w_rem_sh = {r_rem[CNT_W-1:0], r_dvd[DW-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_n};
  assign w_rem_nx = w_ge ? w_rem_sh - {1'b0, r_n} : w_rem_sh;
  assign w_last   = r_iter == IW'(DW - 1);
  assign w_hi     = |r_quo[DW-1:CNT_W];
  // next state; clear overrides everything and DONE is only left by clear/reset
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.i_processor_hlt ? SETTLE : IDLE;
      SETTLE:  w_next = (r_cnt == '0) ? FINISH : DIV;
      DIV:     w_next = w_last ? FINISH : DIV;
      FINISH:  w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (bus.i_clear) w_next = IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // instruction counter, operand capture, restoring divider and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_n     <= '0;
      r_cpi   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_iter  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_dbz   <= 1'b0;
      r_sat   <= 1'b0;
    end else if (bus.i_clear) begin
      r_cnt   <= '0;
      r_n     <= '0;
      r_cpi   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_iter  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_dbz   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_busy <= w_next inside {SETTLE, DIV, FINISH};
      if (r_state == IDLE && bus.i_instr_retired && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (r_state == SETTLE) begin
        r_n    <= r_cnt;
        r_dbz  <= r_cnt == '0;
        r_dvd  <= {bus.i_cycle_count, {FRAC_BITS{1'b0}}};
        r_rem  <= '0;
        r_quo  <= '0;
        r_iter <= '0;
      end
      if (r_state == DIV) begin
        r_rem  <= w_rem_nx;
        r_quo  <= {r_quo[DW-2:0], w_ge};
        r_dvd  <= r_dvd << 1;
        r_iter <= r_iter + 1'b1;
      end
      if (r_state == FINISH) begin
        r_cpi   <= (r_dbz || w_hi) ? '1 : r_quo[CNT_W-1:0];
        r_sat   <= !r_dbz && w_hi;
        r_valid <= 1'b1;
      end
    end
  end
  assign bus.o_instr_count = r_cnt;
  assign bus.o_cpi         = r_cpi;
  assign bus.o_valid       = r_valid;
  assign bus.o_busy        = r_busy;
  assign bus.o_div_by_zero = r_dbz;
  assign bus.o_saturated   = r_sat;
endmodule

// File: tb/tb_cpi_calculator.sv
// tb_cpi_calculator: directed and random halt/divide runs checked against an arithmetic CPI model
module tb_cpi_calculator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cpi_calculator_if #(.CNT_W(16)) bus();
  cpi_calculator #(.CNT_W(16), .FRAC_BITS(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zeros(input string tag);
    chk(tag, {bus.o_instr_count, bus.o_cpi, bus.o_valid, bus.o_busy, bus.o_div_by_zero, bus.o_saturated}, 64'd0);
  endtask
  task automatic run(input int n, input logic [15:0] c, input bit same);
    int lat, busy_cnt, overlap, lat_e;
    longint q;
    logic [15:0] cpi_e;
    bit sat_e;
    @(negedge clk);
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    zeros("clear");
    for (int i = 0; i < n - (same ? 1 : 0); i++) begin
      bus.i_instr_retired = 1'b1;
      @(negedge clk);
      bus.i_instr_retired = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.i_cycle_count = c;
    bus.i_processor_hlt = 1'b1;
    bus.i_instr_retired = same && n > 0;
    lat = -1;
    busy_cnt = 0;
    overlap = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.i_processor_hlt = 1'($urandom_range(0, 1));
      bus.i_instr_retired = 1'($urandom_range(0, 1));
      if (cyc >= 2) bus.i_cycle_count = 16'($urandom);
      if (bus.o_busy) busy_cnt++;
      if (bus.o_busy && bus.o_valid) overlap++;
      if (bus.o_valid && lat < 0) lat = cyc - 1;
    end
    bus.i_processor_hlt = 1'b0;
    bus.i_instr_retired = 1'b0;
    if (n == 0) begin
      lat_e = 2;
      cpi_e = 16'hFFFF;
      sat_e = 1'b0;
    end else begin
      lat_e = 26;
      q = (longint'(c) << 8) / n;
      sat_e = q > 65535;
      cpi_e = sat_e ? 16'hFFFF : 16'(q);
    end
    chk("valid_latency", 64'(lat), 64'(lat_e));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat_e));
    chk("busy_valid_overlap", 64'(overlap), 64'd0);
    chk("instr_count", 64'(bus.o_instr_count), 64'(n));
    chk("cpi", 64'(bus.o_cpi), 64'(cpi_e));
    chk("div_by_zero", 64'(bus.o_div_by_zero), 64'(n == 0));
    chk("saturated", 64'(bus.o_saturated), 64'(sat_e));
    chk("valid_busy", {62'd0, bus.o_valid, bus.o_busy}, 64'd2);
  endtask
  initial begin
    bus.i_clear = 1'b0;
    bus.i_instr_retired = 1'b0;
    bus.i_processor_hlt = 1'b0;
    bus.i_cycle_count = '0;
    #1 zeros("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    zeros("after_reset");
    run(40, 16'd100, 1'b0);
    chk("cpi_2p5", 64'(bus.o_cpi), 64'h0280);
    run(3, 16'd7, 1'b0);
    chk("cpi_597", 64'(bus.o_cpi), 64'h0255);
    run(1, 16'hFFFF, 1'b0);
    run(0, 16'd50, 1'b0);
    run(10, 16'd1234, 1'b1);
    @(negedge clk);
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_instr_retired = 1'b1;
      @(negedge clk);
      bus.i_instr_retired = 1'b0;
    end
    bus.i_cycle_count = 16'd77;
    bus.i_processor_hlt = 1'b1;
    repeat (12) @(negedge clk);
    bus.i_processor_hlt = 1'b0;
    chk("busy_mid_div", 64'(bus.o_busy), 64'd1);
    #2 reset = 1'b1;
    #1 zeros("async_abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    zeros("abort_no_valid");
    bus.i_instr_retired = 1'b1;
    @(negedge clk);
    bus.i_instr_retired = 1'b0;
    chk("count_restart", 64'(bus.o_instr_count), 64'd1);
    run(6, 16'd200, 1'b0);
    run(7, 16'd90, 1'b1);
    @(negedge clk);
    bus.i_clear = 1'b1;
    bus.i_processor_hlt = 1'b1;
    bus.i_instr_retired = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    bus.i_processor_hlt = 1'b0;
    bus.i_instr_retired = 1'b0;
    zeros("clear_beats_halt");
    @(negedge clk);
    chk("idle_after_clear_halt", {62'd0, bus.o_busy, bus.o_valid}, 64'd0);
    for (int r = 0; r < 8; r++)
      run($urandom_range(0, 50), (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
